// File: rtl/peach_pkg.sv
// Shared definitions for the peach core front end: fetch FSM states, NOP and RV32I opcodes.
package peach_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_IDLE = 2'd1,
    ST_READ = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

  // addi x0, x0, 0 -- returned in place of data on a faulting fetch
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/peach_boot_fetch.sv
// Copies ROM into instruction RAM after reset, then serves single outstanding
// instruction fetches from that RAM with a two-cycle request-to-valid latency.
module peach_boot_fetch
  import peach_pkg::*;
#(
  parameter int ROM_WORDS = 4096,
  parameter int MEM_AW    = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic [31:0]       rom_addr,
  input  logic [31:0]       rom_data,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              boot_done,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_pc,
  output logic              fetch_ready,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              fetch_fault,
  input  logic              instr_ack,
  input  logic              flush
);

  if (MEM_AW < 1 || MEM_AW > 30 || ROM_WORDS < 1 || ROM_WORDS > (2 ** MEM_AW)) begin : g_param_check
    $error("peach_boot_fetch: need 1 <= MEM_AW <= 30 and 1 <= ROM_WORDS <= 2**MEM_AW");
  end

  state_e              r_state;
  state_e              w_next;
  logic [MEM_AW-1:0]   r_idx;
  logic [31:0]         r_instr;
  logic [31:0]         r_instr_pc;
  logic                r_fault;
  logic                w_last;
  logic                w_accept;
  logic                w_bad_pc;

  // Misaligned, or word index beyond the RAM (upper index bits nonzero)
  assign w_bad_pc    = (fetch_pc[1:0] != 2'b00) || ((fetch_pc[31:2] >> MEM_AW) != 30'd0);
  assign w_last      = (r_idx == MEM_AW'(ROM_WORDS - 1));
  assign fetch_ready = (r_state == ST_IDLE) && !flush;
  assign w_accept    = fetch_ready && fetch_req;

  assign instr_valid = (r_state == ST_HOLD);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign fetch_fault = r_fault;

  always_comb begin
    w_next    = r_state;
    mem_we    = 1'b0;
    mem_addr  = r_instr_pc[MEM_AW+1:2];
    mem_wdata = 32'd0;
    rom_addr  = {30'(r_idx), 2'b00};
    boot_done = 1'b1;
    case (r_state)
      ST_BOOT: begin
        mem_we    = 1'b1;
        mem_addr  = r_idx;
        mem_wdata = rom_data;
        boot_done = 1'b0;
        if (w_last) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        // Address goes out in the accept cycle so RAM data lands during READ
        mem_addr = fetch_pc[MEM_AW+1:2];
        if (w_accept) w_next = ST_READ;
      end
      ST_READ: w_next = flush ? ST_IDLE : ST_HOLD;
      ST_HOLD: if (flush || instr_ack) w_next = ST_IDLE;
      default: w_next = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_BOOT;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_BOOT && !w_last) r_idx <= r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr    <= 32'd0;
      r_instr_pc <= 32'd0;
      r_fault    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr_pc <= fetch_pc;
        r_fault    <= w_bad_pc;
      end
      // A flush during READ drops the RAM word on the floor
      if (r_state == ST_READ && !flush) r_instr <= r_fault ? NOP_INSTR : mem_rdata;
    end
  end

endmodule

// File: tb/tb_peach_boot_fetch.sv
// Bench for peach_boot_fetch: ROM/RAM models, boot copy, fetch, fault, flush and reset scenarios.
module tb_peach_boot_fetch;

  localparam int ROM_WORDS = 16;
  localparam int MEM_AW    = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic              clk;
  logic              reset;
  logic [31:0]       rom_addr;
  logic [31:0]       rom_data;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              boot_done;
  logic              fetch_req;
  logic [31:0]       fetch_pc;
  logic              fetch_ready;
  logic              instr_valid;
  logic [31:0]       instr;
  logic [31:0]       instr_pc;
  logic              fetch_fault;
  logic              instr_ack;
  logic              flush;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram [2**MEM_AW];

  peach_boot_fetch #(.ROM_WORDS(ROM_WORDS), .MEM_AW(MEM_AW)) dut (
    .clk(clk), .reset(reset),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .boot_done(boot_done),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_ready(fetch_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .fetch_fault(fetch_fault),
    .instr_ack(instr_ack), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational ROM: word i holds A000_0000 + i
  assign rom_data = 32'hA000_0000 + (rom_addr >> 2);

  // Synchronous-read RAM
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic exp_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(2 ** MEM_AW));
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    if (exp_fault(pc)) return NOP;
    return 32'hA000_0000 + (pc >> 2);
  endfunction

  task automatic test_reset();
    reset = 1'b0; fetch_req = 1'b0; fetch_pc = 32'd0; instr_ack = 1'b0; flush = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (boot_done !== 1'b0) begin n_fail++; $display("FAIL reset_boot_done got %b want 0", boot_done); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_ready got %b want 0", fetch_ready); end
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid got %b want 0", instr_valid); end
    n_checks++; if ({instr, instr_pc, fetch_fault} !== 65'd0) begin n_fail++; $display("FAIL reset_data got %h/%h/%b want 0", instr, instr_pc, fetch_fault); end
    n_checks++; if (mem_addr !== '0 || rom_addr !== 32'd0) begin n_fail++; $display("FAIL reset_index got %h/%h want 0", mem_addr, rom_addr); end
  endtask

  // Called at a negedge with reset low; releases it and follows the copy to IDLE
  task automatic run_boot(input string tag);
    reset = 1'b1;
    for (int k = 0; k < ROM_WORDS; k++) begin
      #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== MEM_AW'(k) || mem_wdata !== 32'hA000_0000 + 32'(k) ||
          rom_addr !== 32'(k * 4) || boot_done !== 1'b0)
      begin
        n_fail++;
        $display("FAIL %s_copy[%0d] got we=%b addr=%h data=%h rom=%h done=%b want we=1 addr=%0d data=%h done=0",
                 tag, k, mem_we, mem_addr, mem_wdata, rom_addr, boot_done, k, 32'hA000_0000 + 32'(k));
      end
      @(negedge clk);
    end
    #1;
    n_checks++;
    if (boot_done !== 1'b1 || mem_we !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done got done=%b we=%b ready=%b want 1/0/1", tag, boot_done, mem_we, fetch_ready);
    end
    @(negedge clk); #1;
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL %s_we_after got %b want 0", tag, mem_we); end
  endtask

  task automatic test_boot();
    run_boot("boot");
  endtask

  // Entered just after a negedge in IDLE; leaves just after a negedge in IDLE
  task automatic do_fetch(input logic [31:0] pc, input int hold, input bit ack_early, input string tag);
    logic [31:0] ei;
    logic        ef;
    ei = exp_instr(pc);
    ef = exp_fault(pc);
    fetch_req = 1'b1; fetch_pc = pc;
    #1;
    n_checks++;
    if (fetch_ready !== 1'b1 || mem_addr !== pc[MEM_AW+1:2]) begin
      n_fail++; $display("FAIL %s_accept got ready=%b addr=%h want 1/%h", tag, fetch_ready, mem_addr, pc[MEM_AW+1:2]);
    end
    @(negedge clk);
    fetch_req = 1'b0; fetch_pc = $urandom(); instr_ack = ack_early;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_read got valid=%b ready=%b want 0/0", tag, instr_valid, fetch_ready);
    end
    @(negedge clk);
    instr_ack = 1'b0;
    for (int h = 0; h <= hold; h++) begin
      #1;
      n_checks++;
      if (instr_valid !== 1'b1 || instr !== ei || instr_pc !== pc || fetch_fault !== ef) begin
        n_fail++;
        $display("FAIL %s_hold[%0d] got v=%b i=%h pc=%h f=%b want 1/%h/%h/%b", tag, h, instr_valid, instr, instr_pc, fetch_fault, ei, pc, ef);
      end
      if (h < hold) @(negedge clk);
    end
    instr_ack = 1'b1;
    @(negedge clk);
    instr_ack = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_ack got valid=%b ready=%b want 0/1", tag, instr_valid, fetch_ready);
    end
  endtask

  task automatic test_fetch();
    do_fetch(32'h0000_0008, 2, 1'b0, "fetch8");
    do_fetch(32'h0000_003C, 0, 1'b1, "fetch_last");
    do_fetch(32'h0000_0000, 1, 1'b0, "fetch0");
  endtask

  task automatic test_faults();
    do_fetch(32'h0000_0006, 1, 1'b0, "fault_misalign");
    do_fetch(32'h0000_0040, 0, 1'b0, "fault_range");
    do_fetch(32'h8000_0004, 0, 1'b0, "fault_high");
  endtask

  task automatic test_flush();
    // flush in READ
    fetch_req = 1'b1; fetch_pc = 32'd4;
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_read got valid=%b ready=%b want 0/1", instr_valid, fetch_ready);
    end
    @(negedge clk); #1;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL flush_read_late got valid=%b want 0", instr_valid); end
    // flush in IDLE blocks acceptance
    fetch_req = 1'b1; fetch_pc = 32'd4; flush = 1'b1;
    #1;
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready got %b want 0", fetch_ready); end
    @(negedge clk);
    fetch_req = 1'b0; flush = 1'b0;
    #1;
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL flush_idle_state got ready=%b want 1", fetch_ready); end
    // flush together with ack in HOLD
    fetch_req = 1'b1; fetch_pc = 32'd12;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (instr_valid !== 1'b1 || instr !== exp_instr(32'd12)) begin
      n_fail++; $display("FAIL flush_hold_pre got v=%b i=%h want 1/%h", instr_valid, instr, exp_instr(32'd12));
    end
    flush = 1'b1; instr_ack = 1'b1;
    @(negedge clk);
    flush = 1'b0; instr_ack = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || fetch_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_hold got valid=%b ready=%b want 0/1", instr_valid, fetch_ready);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 24; n++) begin
      logic [31:0] pc;
      case ($urandom_range(0, 5))
        0:       pc = $urandom();
        1:       pc = 32'($urandom_range(0, 90));
        default: pc = 32'($urandom_range(0, 17)) << 2;
      endcase
      do_fetch(pc, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_reset_mid();
    // mid-fetch: reset while holding a result
    fetch_req = 1'b1; fetch_pc = 32'd8;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'd0 || instr_pc !== 32'd0 || fetch_fault !== 1'b0 ||
        boot_done !== 1'b0 || fetch_ready !== 1'b0)
    begin
      n_fail++;
      $display("FAIL reset_fetch got v=%b i=%h pc=%h f=%b done=%b rdy=%b want all 0",
               instr_valid, instr, instr_pc, fetch_fault, boot_done, fetch_ready);
    end
    @(negedge clk);
    // mid-copy: reset at index 7
    reset = 1'b1;
    repeat (7) @(negedge clk);
    #1;
    n_checks++; if (mem_addr !== MEM_AW'(7)) begin n_fail++; $display("FAIL reset_copy_idx got %0d want 7", mem_addr); end
    reset = 1'b0;
    #1;
    n_checks++;
    if (mem_addr !== '0 || boot_done !== 1'b0 || fetch_ready !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_copy got addr=%0d done=%b rdy=%b v=%b want 0/0/0/0", mem_addr, boot_done, fetch_ready, instr_valid);
    end
    @(negedge clk);
    run_boot("reboot");
    do_fetch(32'h0000_0014, 1, 1'b0, "post_reboot");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired n_checks=%0d want completion", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_boot();
    test_fetch();
    test_faults();
    test_flush();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/peach_boot_fetch.md
PEACH_BOOT_FETCH -- requirements
Module: peach_boot_fetch

Interface
REQ-001 SHALL have parameter ROM_WORDS, default 4096: number of 32-bit words copied from ROM at boot.
REQ-002 SHALL have parameter MEM_AW, default 12: word-address width of instruction RAM; RAM holds 2^MEM_AW words.
REQ-003 SHALL have ports:
 clk  in  1  single clock, all state on rising edge.
 reset  in  1  asynchronous, active-low reset.
 rom_addr  out  32  byte address to combinational ROM (word index << 2).
 rom_data  in  32  ROM word at rom_addr, same cycle.
 mem_we  out  1  RAM write enable.
 mem_addr  out  MEM_AW  RAM word address.
 mem_wdata  out  32  RAM write data.
 mem_rdata  in  32  RAM read data, valid one cycle after mem_addr (synchronous read).
 boot_done  out  1  copy complete; fetch port live.
 fetch_req  in  1  core requests instruction at fetch_pc.
 fetch_pc  in  32  byte address of requested instruction.
 fetch_ready  out  1  request accepted this cycle if fetch_req=1.
 instr_valid  out  1  instr/instr_pc/fetch_fault valid.
 instr  out  32  fetched instruction word.
 instr_pc  out  32  address the instr belongs to.
 fetch_fault  out  1  request was misaligned or out of range.
 instr_ack  in  1  core consumed instr this cycle.
 flush  in  1  discard any in-flight or held fetch.

Function
REQ-004 SHALL implement FSM states BOOT, IDLE, READ, HOLD.
REQ-005 BOOT: index i from 0; each cycle rom_addr=i<<2, mem_we=1, mem_addr=i, mem_wdata=rom_data; i increments; after i=ROM_WORDS-1 written, next state IDLE. Copy takes exactly ROM_WORDS cycles.
REQ-006 mem_we SHALL be 0 in every state except BOOT.
REQ-007 boot_done SHALL be 0 in BOOT and 1 in all other states.
REQ-008 fetch_ready SHALL equal (state==IDLE) and not flush.
REQ-009 Accept (fetch_req and fetch_ready) in cycle T: fetch_pc latched into instr_pc; mem_addr=fetch_pc[MEM_AW+1:2] combinationally in T; next state READ.
REQ-010 Fault: if fetch_pc[1:0]!=0 or fetch_pc[31:2]>=2^MEM_AW, fetch_fault=1 and instr=32'h00000013 (NOP); otherwise fetch_fault=0 and instr=mem_rdata captured at end of T+1.
REQ-011 READ (T+1): capture result; next state HOLD; instr_valid=1 from T+2. Request-to-valid latency 2 cycles.
REQ-012 HOLD: instr_valid, instr, instr_pc, fetch_fault held stable until instr_ack=1; on ack next state IDLE, instr_valid=0 next cycle.
REQ-013 instr_ack while instr_valid=0 SHALL be ignored.
REQ-014 flush in READ or HOLD: next state IDLE, instr_valid=0 next cycle, captured data discarded; flush has priority over instr_ack.
REQ-015 flush in IDLE: no request accepted that cycle; no other effect. flush, fetch_req, instr_ack ignored in BOOT.
REQ-016 ROM_WORDS > 2^MEM_AW SHALL be a elaboration error; ROM_WORDS < 2^MEM_AW leaves remaining RAM unwritten.

Reset
REQ-017 reset=0 SHALL asynchronously force: state BOOT, i=0, instr_valid=0, instr=0, instr_pc=0, fetch_fault=0; outputs boot_done=0, fetch_ready=0.
REQ-018 Reset asserted mid-copy or mid-fetch SHALL abandon the operation; copy restarts at index 0 after release.
REQ-019 First BOOT write SHALL occur in the first rising edge cycle after reset deasserts.

Structure
REQ-020 State enum, NOP constant (32'h00000013) and RV32I opcode constants SHALL live in shared package peach_pkg.
REQ-021 Block SHALL be a single module; ROM and RAM are instantiated outside it; no sub-module.

Verification
REQ-022 Boot: ROM_WORDS=16, MEM_AW=4, ROM[i]=32'hA000_0000+i -> 16 writes, mem_addr 0..15 with matching data, boot_done=1 on cycle 17, mem_we=0 after.
REQ-023 Fetch: after boot, fetch_pc=32'h0000_0008 -> instr_valid 2 cycles later, instr=32'hA000_0002, instr_pc=8, fetch_fault=0; held 3 cycles until instr_ack, then cleared.
REQ-024 Faults: fetch_pc=32'h0000_0006 -> fetch_fault=1, instr=32'h00000013; fetch_pc=32'h0000_0040 -> fetch_fault=1.
REQ-025 Flush: accept fetch_pc=4, assert flush in READ -> instr_valid never rises, fetch_ready=1 next cycle; flush and instr_ack together in HOLD -> valid drops.
REQ-026 Reset mid-copy at index 7 -> all outputs reset immediately; after release copy restarts at mem_addr 0, boot_done after 16 cycles.
